// File: rtl/pattern_injector_if.sv
// Cache-line stream bundle: one line per valid/ready handshake.
// The master drives valid and data; the slave drives ready.
interface pattern_injector_if #(
    parameter int CL_SIZE = 64
);
    logic                 valid;
    logic                 ready;
    logic [CL_SIZE*8-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pattern_injector.sv
// Overwrites a 1..NW-word pattern into snooped cache lines, one 32-bit word per cycle,
// starting at a word offset and spilling the remainder into the next accepted line.
module pattern_injector #(
    parameter int CL_SIZE = 64
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    input  logic [CL_SIZE*8-1:0]             i_pattern,
    input  logic [4:0]                       i_pattern_size,
    input  logic [$clog2(CL_SIZE/4)-1:0]     i_offset,
    pattern_injector_if.slave                up,
    pattern_injector_if.master               dn,
    output logic                             o_busy,
    output logic [4:0]                       o_pending,
    output logic                             o_op_end,
    output logic                             o_err
);
    localparam int NW = CL_SIZE / 4;
    localparam int WW = $clog2(NW);

    typedef logic [NW-1:0][31:0] line_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LINE,
        WRITE,
        OUTPUT,
        DONE
    } state_t;

    state_t         state_q, state_d;
    line_t          line_q, line_d;
    line_t          pattern_q, pattern_d;
    logic [4:0]     size_q, size_d;
    logic [4:0]     p_q, p_d;
    logic [WW-1:0]  w_q, w_d;
    logic [4:0]     pending_q, pending_d;
    logic           err_q, err_d;
    logic           size_legal;

    assign size_legal = (i_pattern_size != 5'd0) && (i_pattern_size <= 5'(NW));

    // NOTE: every signal gets its default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        pattern_d = pattern_q;
        size_d    = size_q;
        p_d       = p_q;
        w_d       = w_q;
        pending_d = pending_q;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (size_legal) begin
                        pattern_d = i_pattern;
                        size_d    = i_pattern_size;
                        p_d       = 5'd0;
                        w_d       = i_offset;
                        pending_d = i_pattern_size;
                        state_d   = WAIT_LINE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT_LINE: begin
                if (up.valid) begin
                    line_d  = up.data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                line_d[w_q] = pattern_q[p_q[WW-1:0]];
                p_d         = p_q + 5'd1;
                w_d         = w_q + WW'(1);
                pending_d   = pending_q - 5'd1;
                // Stop on the last pattern word or on the last word of the line.
                if ((p_d == size_q) || (&w_q)) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (dn.ready) begin
                    if (pending_q != 5'd0) begin
                        w_d     = '0;
                        state_d = WAIT_LINE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            line_q    <= '0;
            pattern_q <= '0;
            size_q    <= 5'd0;
            p_q       <= 5'd0;
            w_q       <= '0;
            pending_q <= 5'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            pattern_q <= pattern_d;
            size_q    <= size_d;
            p_q       <= p_d;
            w_q       <= w_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign up.ready  = (state_q == WAIT_LINE);
    assign dn.valid  = (state_q == OUTPUT);
    assign dn.data   = line_q;
    assign o_busy    = (state_q != IDLE);
    assign o_pending = pending_q;
    assign o_op_end  = (state_q == DONE);
    assign o_err     = err_q;
endmodule

// File: tb/tb_pattern_injector.sv
// Directed self-checking bench for pattern_injector: aligned, split, backpressure,
// illegal size, mid-write reset and full-line injections.
module tb_pattern_injector;
    localparam int CL_SIZE = 64;
    localparam int LW      = CL_SIZE * 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [LW-1:0] pattern;
    logic [4:0]    pattern_size;
    logic [3:0]    offset;
    logic          busy;
    logic [4:0]    pending;
    logic          op_end;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    pattern_injector_if #(.CL_SIZE(CL_SIZE)) up_if ();
    pattern_injector_if #(.CL_SIZE(CL_SIZE)) dn_if ();

    pattern_injector #(.CL_SIZE(CL_SIZE)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_pattern      (pattern),
        .i_pattern_size (pattern_size),
        .i_offset       (offset),
        .up             (up_if.slave),
        .dn             (dn_if.master),
        .o_busy         (busy),
        .o_pending      (pending),
        .o_op_end       (op_end),
        .o_err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] fill(input logic [31:0] v);
        logic [LW-1:0] l;
        for (int k = 0; k < CL_SIZE / 4; k++) l[32*k +: 32] = v;
        return l;
    endfunction

    function automatic logic [LW-1:0] setw(input logic [LW-1:0] l, input int k, input logic [31:0] v);
        logic [LW-1:0] r;
        r = l;
        r[32*k +: 32] = v;
        return r;
    endfunction

    task automatic request(input logic [LW-1:0] pat, input logic [4:0] size, input logic [3:0] off);
        pattern      = pat;
        pattern_size = size;
        offset       = off;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic feed_line(input string tag, input logic [LW-1:0] line);
        int n;
        n = 0;
        while (!up_if.ready && n < 50) begin
            tick();
            n++;
        end
        if (!up_if.ready) check({tag, " ready timeout"}, 1'b0, 1'b1);
        up_if.valid = 1'b1;
        up_if.data  = line;
        tick();
        up_if.valid = 1'b0;
        up_if.data  = '0;
    endtask

    task automatic wait_out(input string tag, input int exp_cycles, input logic [LW-1:0] exp_line);
        int n;
        n = 0;
        while (!dn_if.valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, " write cycles"}, n, exp_cycles);
        check({tag, " line"}, dn_if.data, exp_line);
    endtask

    task automatic handshake();
        dn_if.ready = 1'b1;
        tick();
        dn_if.ready = 1'b0;
    endtask

    task automatic run_aligned(input string tag);
        logic [LW-1:0] pat;
        logic [LW-1:0] exp;
        pat = '0;
        exp = fill(32'hAAAA_AAAA);
        for (int k = 0; k < 4; k++) begin
            pat = setw(pat, k, 32'h11 * (k + 1));
            exp = setw(exp, k, 32'h11 * (k + 1));
        end
        request(pat, 5'd4, 4'd0);
        check({tag, " ready in WAIT_LINE"}, up_if.ready, 1'b1);
        check({tag, " pending at start"}, pending, 5'd4);
        check({tag, " busy"}, busy, 1'b1);
        feed_line(tag, fill(32'hAAAA_AAAA));
        wait_out(tag, 4, exp);
        check({tag, " pending at output"}, pending, 5'd0);
        handshake();
        check({tag, " op_end pulse"}, op_end, 1'b1);
        check({tag, " valid dropped"}, dn_if.valid, 1'b0);
        tick();
        check({tag, " op_end single"}, op_end, 1'b0);
        check({tag, " idle"}, busy, 1'b0);
    endtask

    initial begin
        logic [LW-1:0] pat;
        logic [LW-1:0] exp;

        rst          = 1'b1;
        start        = 1'b0;
        pattern      = '0;
        pattern_size = 5'd0;
        offset       = 4'd0;
        up_if.valid  = 1'b0;
        up_if.data   = '0;
        dn_if.ready  = 1'b0;
        tick();
        tick();

        check("reset cl_ready", up_if.ready, 1'b0);
        check("reset cl_valid", dn_if.valid, 1'b0);
        check("reset cache_line", dn_if.data, '0);
        check("reset busy", busy, 1'b0);
        check("reset pending", pending, 5'd0);
        check("reset op_end", op_end, 1'b0);
        check("reset err", err, 1'b0);
        rst = 1'b0;
        tick();

        // T1 aligned
        run_aligned("t1");

        // T2 split across two lines
        pat = '0;
        for (int k = 0; k < 5; k++) pat = setw(pat, k, 32'hA0 + k);
        request(pat, 5'd5, 4'd13);
        feed_line("t2a", fill(32'h5555_5555));
        exp = fill(32'h5555_5555);
        exp = setw(exp, 13, 32'hA0);
        exp = setw(exp, 14, 32'hA1);
        exp = setw(exp, 15, 32'hA2);
        wait_out("t2a", 3, exp);
        check("t2a pending at handshake", pending, 5'd2);
        handshake();
        check("t2 continuation ready", up_if.ready, 1'b1);
        check("t2 no early op_end", op_end, 1'b0);
        feed_line("t2b", '0);
        exp = '0;
        exp = setw(exp, 0, 32'hA3);
        exp = setw(exp, 1, 32'hA4);
        wait_out("t2b", 2, exp);
        check("t2b pending", pending, 5'd0);
        handshake();
        check("t2 op_end", op_end, 1'b1);
        tick();
        check("t2 op_end single", op_end, 1'b0);
        check("t2 idle", busy, 1'b0);

        // T3 backpressure
        pat = '0;
        pat = setw(pat, 0, 32'hC0C0_0001);
        pat = setw(pat, 1, 32'hC0C0_0002);
        request(pat, 5'd2, 4'd6);
        feed_line("t3", fill(32'h1234_5678));
        exp = fill(32'h1234_5678);
        exp = setw(exp, 6, 32'hC0C0_0001);
        exp = setw(exp, 7, 32'hC0C0_0002);
        wait_out("t3", 2, exp);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3 held valid", dn_if.valid, 1'b1);
            check("t3 held line", dn_if.data, exp);
        end
        handshake();
        check("t3 single transfer", dn_if.valid, 1'b0);
        check("t3 op_end", op_end, 1'b1);
        tick();
        check("t3 no second transfer", dn_if.valid, 1'b0);

        // T4 illegal sizes
        request('1, 5'd0, 4'd0);
        check("t4 err size0", err, 1'b1);
        check("t4 busy size0", busy, 1'b0);
        check("t4 ready size0", up_if.ready, 1'b0);
        tick();
        check("t4 err pulse size0", err, 1'b0);
        request('1, 5'd17, 4'd0);
        check("t4 err size17", err, 1'b1);
        check("t4 busy size17", busy, 1'b0);
        check("t4 ready size17", up_if.ready, 1'b0);
        tick();
        check("t4 err pulse size17", err, 1'b0);

        // T5 reset during the second WRITE cycle
        pat = '0;
        for (int k = 0; k < 8; k++) pat = setw(pat, k, 32'hBB00 + k);
        request(pat, 5'd8, 4'd0);
        feed_line("t5", fill(32'h7777_7777));
        tick();
        rst = 1'b1;
        tick();
        check("t5 reset cl_ready", up_if.ready, 1'b0);
        check("t5 reset cl_valid", dn_if.valid, 1'b0);
        check("t5 reset cache_line", dn_if.data, '0);
        check("t5 reset busy", busy, 1'b0);
        check("t5 reset pending", pending, 5'd0);
        check("t5 reset op_end", op_end, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5 no output after abort", dn_if.valid, 1'b0);
        end
        run_aligned("t5 fresh");

        // T6 full line with a stray start during WRITE
        pat = '0;
        for (int k = 0; k < 16; k++) pat = setw(pat, k, 32'hF000 + k);
        request(pat, 5'd16, 4'd0);
        feed_line("t6", fill(32'hDEAD_BEEF));
        pattern      = fill(32'h9999_9999);
        pattern_size = 5'd3;
        offset       = 4'd5;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        // One of the 16 write cycles was spent above.
        wait_out("t6", 15, pat);
        check("t6 pending", pending, 5'd0);
        handshake();
        check("t6 op_end", op_end, 1'b1);
        tick();
        check("t6 idle", busy, 1'b0);
        check("t6 stray start ignored", up_if.ready, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
